// File: rtl/sram_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_axi_bridge_pkg
// Description : Shared FSM encoding, AXI size codes, kseg remap constants and
//               request record for the SRAM-to-AXI bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_axi_bridge_pkg;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RD_ADDR = 3'd1;
    localparam logic [2:0] c_ST_RD_DATA = 3'd2;
    localparam logic [2:0] c_ST_WR_ADDR = 3'd3;
    localparam logic [2:0] c_ST_WR_RESP = 3'd4;

    localparam logic [2:0] c_SIZE_BYTE = 3'd0;
    localparam logic [2:0] c_SIZE_HALF = 3'd1;
    localparam logic [2:0] c_SIZE_WORD = 3'd2;

    // kseg0 (100) and kseg1 (101) share the top two bits 2'b10
    localparam logic [1:0] c_KSEG_HI_MATCH = 2'b10;
    localparam logic [2:0] c_KSEG_HI_CLR   = 3'b000;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        port_e       port;
    } req_t;

    function automatic logic [31:0] kseg_map(input logic [31:0] addr);
        return (addr[31:30] == c_KSEG_HI_MATCH) ? {c_KSEG_HI_CLR, addr[28:0]} : addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_axi_bridge_size_dec.sv
`default_nettype none
// ============================================================================
// Module      : sram_axi_size_dec
// Description : Decodes SRAM byte write enables into AXI size and strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_axi_size_dec
    import sram_axi_bridge_pkg::*;
(
    input  logic [3:0] i_wen,
    output logic [2:0] o_size,
    output logic [3:0] o_strb
);

    always_comb begin
        o_size = c_SIZE_BYTE;
        case (i_wen)
            4'b1111:          o_size = c_SIZE_WORD;
            4'b0011, 4'b1100: o_size = c_SIZE_HALF;
            default:          o_size = c_SIZE_BYTE;
        endcase
    end

    assign o_strb = i_wen;

endmodule
`default_nettype wire

// File: rtl/sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : sram_axi_bridge
// Description : Converts core SRAM inst/data accesses into single-beat AXI
//               transactions, stalling the core until each completes.
//               Optional macro SRAM_AXI_KSEG_MAP_EN folds kseg0/kseg1 to
//               physical addresses on araddr/awaddr.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_sram_en,
    input  logic [AW-1:0] inst_sram_addr,
    output logic [DW-1:0] inst_sram_rdata,
    input  logic          data_sram_en,
    input  logic [3:0]    data_sram_wen,
    input  logic [AW-1:0] data_sram_addr,
    input  logic [DW-1:0] data_sram_wdata,
    output logic [DW-1:0] data_sram_rdata,
    output logic          stallreq,
    output logic [AW-1:0] araddr,
    output logic [2:0]    arsize,
    output logic          arvalid,
    input  logic          arready,
    input  logic [DW-1:0] rdata,
    input  logic          rvalid,
    output logic          rready,
    output logic [AW-1:0] awaddr,
    output logic [2:0]    awsize,
    output logic          awvalid,
    input  logic          awready,
    output logic [DW-1:0] wdata,
    output logic [3:0]    wstrb,
    output logic          wvalid,
    input  logic          wready,
    input  logic          bvalid,
    output logic          bready
);

    logic [2:0]    r_state;
    req_t          r_req;
    logic          r_inst_served;
    logic          r_data_served;
    logic [DW-1:0] r_inst_rdata;
    logic [DW-1:0] r_data_rdata;
    logic          r_aw_done;
    logic          r_w_done;

    logic          w_inst_need;
    logic          w_data_need;
    logic          w_aw_fin;
    logic          w_w_fin;
    logic [AW-1:0] w_bus_addr;

    assign w_inst_need = inst_sram_en & ~r_inst_served;
    assign w_data_need = data_sram_en & ~r_data_served;
    assign stallreq    = rst & (w_data_need | w_inst_need | (r_state != c_ST_IDLE));

`ifdef SRAM_AXI_KSEG_MAP_EN
    assign w_bus_addr = kseg_map(r_req.addr);
`else
    assign w_bus_addr = r_req.addr;
`endif

    assign araddr  = {w_bus_addr[AW-1:2], 2'b00};
    assign arsize  = c_SIZE_WORD;
    assign arvalid = (r_state == c_ST_RD_ADDR);
    assign rready  = (r_state == c_ST_RD_DATA);
    assign awaddr  = w_bus_addr;
    assign awvalid = (r_state == c_ST_WR_ADDR) & ~r_aw_done;
    assign wvalid  = (r_state == c_ST_WR_ADDR) & ~r_w_done;
    assign wdata   = r_req.wdata;
    assign bready  = (r_state == c_ST_WR_RESP);

    // A channel that is still valid completes as soon as its ready is seen
    assign w_aw_fin = r_aw_done | awready;
    assign w_w_fin  = r_w_done  | wready;

    assign inst_sram_rdata = r_inst_rdata;
    assign data_sram_rdata = r_data_rdata;

    sram_axi_size_dec u_size_dec (
        .i_wen  (r_req.wen),
        .o_size (awsize),
        .o_strb (wstrb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_ST_IDLE;
            r_req         <= '0;
            r_inst_served <= 1'b0;
            r_data_served <= 1'b0;
            r_inst_rdata  <= '0;
            r_data_rdata  <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
        end else begin
            // The unstalled cycle is when the core consumes the access
            if (!stallreq) begin
                r_inst_served <= 1'b0;
                r_data_served <= 1'b0;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_data_need) begin
                        r_req   <= '{addr: data_sram_addr, wen: data_sram_wen,
                                     wdata: data_sram_wdata, port: PORT_DATA};
                        r_state <= (data_sram_wen == 4'b0000) ? c_ST_RD_ADDR : c_ST_WR_ADDR;
                    end else if (w_inst_need) begin
                        r_req   <= '{addr: inst_sram_addr, wen: 4'b0000,
                                     wdata: 32'd0, port: PORT_INST};
                        r_state <= c_ST_RD_ADDR;
                    end
                end
                c_ST_RD_ADDR: begin
                    if (arready) r_state <= c_ST_RD_DATA;
                end
                c_ST_RD_DATA: begin
                    if (rvalid) begin
                        if (r_req.port == PORT_DATA) begin
                            r_data_rdata  <= rdata;
                            r_data_served <= 1'b1;
                        end else begin
                            r_inst_rdata  <= rdata;
                            r_inst_served <= 1'b1;
                        end
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_WR_ADDR: begin
                    if (w_aw_fin && w_w_fin) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= c_ST_WR_RESP;
                    end else begin
                        if (awready) r_aw_done <= 1'b1;
                        if (wready)  r_w_done  <= 1'b1;
                    end
                end
                c_ST_WR_RESP: begin
                    if (bvalid) begin
                        r_data_served <= 1'b1;
                        r_state       <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_axi_bridge
// Description : Directed self-checking bench for sram_axi_bridge with an
//               address/write-attribute scoreboard. Honours SRAM_AXI_KSEG_MAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strb;
        logic [31:0] data;
    } wr_exp_t;

    int          checks = 0;
    int          errors = 0;
    int          ar_cnt = 0;
    int          aw_cnt = 0;
    int          w_cnt  = 0;
    logic [31:0] exp_ar_q[$];
    wr_exp_t     exp_wr_q[$];

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .stallreq        (stallreq),
        .araddr          (araddr),
        .arsize          (arsize),
        .arvalid         (arvalid),
        .arready         (arready),
        .rdata           (rdata),
        .rvalid          (rvalid),
        .rready          (rready),
        .awaddr          (awaddr),
        .awsize          (awsize),
        .awvalid         (awvalid),
        .awready         (awready),
        .wdata           (wdata),
        .wstrb           (wstrb),
        .wvalid          (wvalid),
        .wready          (wready),
        .bvalid          (bvalid),
        .bready          (bready)
    );

    always @(posedge clk) begin
        if (arvalid && arready) ar_cnt <= ar_cnt + 1;
        if (awvalid && awready) aw_cnt <= aw_cnt + 1;
        if (wvalid && wready)   w_cnt  <= w_cnt + 1;
    end

    function automatic logic [31:0] map_addr(input logic [31:0] a);
        logic [31:0] r;
        r = a;
`ifdef SRAM_AXI_KSEG_MAP_EN
        if (a[31:29] == 3'b100 || a[31:29] == 3'b101) r[31:29] = 3'b000;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic serve_read(input int ar_dly, input int r_dly, input logic [31:0] data);
        logic [31:0] exp;
        int n;
        n = 0;
        while (arvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("ar_wait", {31'd0, arvalid}, 32'd1);
        exp = (exp_ar_q.size() > 0) ? exp_ar_q.pop_front() : 32'hDEAD_BEEF;
        for (int i = 0; i < ar_dly; i++) begin
            tick();
            chk("ar_hold", {31'd0, arvalid}, 32'd1);
        end
        chk("araddr", araddr, exp);
        chk("arsize", {29'd0, arsize}, 32'd2);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1;
        chk("ar_drop", {31'd0, arvalid}, 32'd0);
        chk("rready", {31'd0, rready}, 32'd1);
        for (int i = 0; i < r_dly; i++) begin
            tick();
            chk("r_stall", {31'd0, stallreq}, 32'd1);
        end
        rvalid = 1'b1;
        rdata  = data;
        tick();
        rvalid = 1'b0;
        rdata  = 32'd0;
        #1;
        chk("rready_drop", {31'd0, rready}, 32'd0);
    endtask

    task automatic serve_write(input int aw_dly, input int w_dly);
        wr_exp_t exp;
        int n;
        int a0;
        int w0;
        int last;
        n = 0;
        while (awvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("aw_wait", {31'd0, awvalid}, 32'd1);
        exp = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : '1;
        chk("awaddr", awaddr, exp.addr);
        chk("awsize", {29'd0, awsize}, {29'd0, exp.size});
        chk("wstrb", {28'd0, wstrb}, {28'd0, exp.strb});
        chk("wdata", wdata, exp.data);
        a0   = aw_cnt;
        w0   = w_cnt;
        last = (aw_dly > w_dly) ? aw_dly : w_dly;
        for (int c = 0; c <= last; c++) begin
            chk("awvalid_seq", {31'd0, awvalid}, {31'd0, (c <= aw_dly)});
            chk("wvalid_seq", {31'd0, wvalid}, {31'd0, (c <= w_dly)});
            awready = (c >= aw_dly);
            wready  = (c >= w_dly);
            tick();
        end
        awready = 1'b0;
        wready  = 1'b0;
        #1;
        chk("aw_done", {31'd0, awvalid}, 32'd0);
        chk("w_done", {31'd0, wvalid}, 32'd0);
        chk("aw_count", aw_cnt, a0 + 1);
        chk("w_count", w_cnt, w0 + 1);
        tick();
        chk("bready", {31'd0, bready}, 32'd1);
        chk("b_stall", {31'd0, stallreq}, 32'd1);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        #1;
        chk("b_release", {31'd0, stallreq}, 32'd0);
        chk("bready_drop", {31'd0, bready}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        rst             = 1'b0;
        inst_sram_en    = 1'b0;
        inst_sram_addr  = 32'd0;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'd0;
        data_sram_addr  = 32'd0;
        data_sram_wdata = 32'd0;
        arready         = 1'b0;
        rdata           = 32'd0;
        rvalid          = 1'b0;
        awready         = 1'b0;
        wready          = 1'b0;
        bvalid          = 1'b0;

        // reset state
        repeat (2) tick();
        inst_sram_en = 1'b1;
        #1;
        chk("rst_stallreq", {31'd0, stallreq}, 32'd0);
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
        chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
        chk("rst_bready", {31'd0, bready}, 32'd0);
        chk("rst_inst_rdata", inst_sram_rdata, 32'd0);
        chk("rst_data_rdata", data_sram_rdata, 32'd0);
        inst_sram_en = 1'b0;
        rst = 1'b1;
        tick();

        // inst fetch from kseg1 boot vector
        inst_sram_en   = 1'b1;
        inst_sram_addr = 32'hBFC0_0000;
        exp_ar_q.push_back(map_addr(32'hBFC0_0000));
        #1;
        chk("t1_stall_req", {31'd0, stallreq}, 32'd1);
        serve_read(2, 3, 32'h3C1D_0000);
        chk("t1_stall_drop", {31'd0, stallreq}, 32'd0);
        chk("t1_inst_rdata", inst_sram_rdata, 32'h3C1D_0000);
        inst_sram_en = 1'b0;
        tick();
        chk("t1_inst_rdata_hold", inst_sram_rdata, 32'h3C1D_0000);
        chk("t1_idle_stall", {31'd0, stallreq}, 32'd0);
        chk("t1_idle_arvalid", {31'd0, arvalid}, 32'd0);

        // byte store, W accepted two cycles ahead of AW
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'b1000;
        data_sram_addr  = 32'h8000_1003;
        data_sram_wdata = 32'hAB00_0000;
        exp_wr_q.push_back('{addr: map_addr(32'h8000_1003), size: 3'd0,
                             strb: 4'b1000, data: 32'hAB00_0000});
        serve_write(2, 0);
        data_sram_en = 1'b0;
        tick();

        // simultaneous data load and inst fetch: data goes first
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'b0000;
        data_sram_addr = 32'h0000_0200;
        inst_sram_en   = 1'b1;
        inst_sram_addr = 32'h0000_0100;
        exp_ar_q.push_back(32'h0000_0200);
        exp_ar_q.push_back(32'h0000_0100);
        serve_read(0, 1, 32'h1111_1111);
        chk("t3_still_stalled", {31'd0, stallreq}, 32'd1);
        chk("t3_data_rdata_a", data_sram_rdata, 32'h1111_1111);
        serve_read(0, 1, 32'h2222_2222);
        chk("t3_stall_drop", {31'd0, stallreq}, 32'd0);
        chk("t3_data_rdata", data_sram_rdata, 32'h1111_1111);
        chk("t3_inst_rdata", inst_sram_rdata, 32'h2222_2222);
        data_sram_en = 1'b0;
        inst_sram_en = 1'b0;
        tick();

        // halfword then word store
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'b1100;
        data_sram_addr  = 32'h0000_0302;
        data_sram_wdata = 32'h1234_0000;
        exp_wr_q.push_back('{addr: 32'h0000_0302, size: 3'd1, strb: 4'b1100, data: 32'h1234_0000});
        serve_write(0, 0);
        data_sram_en = 1'b0;
        tick();
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'b1111;
        data_sram_addr  = 32'h0000_0404;
        data_sram_wdata = 32'hCAFE_F00D;
        exp_wr_q.push_back('{addr: 32'h0000_0404, size: 3'd2, strb: 4'b1111, data: 32'hCAFE_F00D});
        serve_write(1, 3);
        data_sram_en = 1'b0;
        tick();
        chk("t4_data_rdata_kept", data_sram_rdata, 32'h1111_1111);

        // asynchronous reset while waiting for read data
        inst_sram_en   = 1'b1;
        inst_sram_addr = 32'h0000_0500;
        tick();
        chk("t5_arvalid", {31'd0, arvalid}, 32'd1);
        chk("t5_araddr", araddr, 32'h0000_0500);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1;
        chk("t5_rready", {31'd0, rready}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("t5_rst_rready", {31'd0, rready}, 32'd0);
        chk("t5_rst_stallreq", {31'd0, stallreq}, 32'd0);
        chk("t5_rst_inst_rdata", inst_sram_rdata, 32'd0);
        chk("t5_rst_data_rdata", data_sram_rdata, 32'd0);
        inst_sram_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("t5_post_stallreq", {31'd0, stallreq}, 32'd0);
        chk("t5_post_arvalid", {31'd0, arvalid}, 32'd0);
        chk("t5_post_rready", {31'd0, rready}, 32'd0);

        // back-to-back fetches of the same address
        inst_sram_en   = 1'b1;
        inst_sram_addr = 32'h0000_0600;
        exp_ar_q.push_back(32'h0000_0600);
        exp_ar_q.push_back(32'h0000_0600);
        a0 = ar_cnt;
        serve_read(1, 0, 32'hAAAA_0001);
        chk("t6_stall_drop", {31'd0, stallreq}, 32'd0);
        chk("t6_rdata_1", inst_sram_rdata, 32'hAAAA_0001);
        tick();
        chk("t6_restall", {31'd0, stallreq}, 32'd1);
        chk("t6_rdata_hold", inst_sram_rdata, 32'hAAAA_0001);
        serve_read(0, 0, 32'hAAAA_0002);
        chk("t6_ar_count", ar_cnt, a0 + 2);
        chk("t6_rdata_2", inst_sram_rdata, 32'hAAAA_0002);
        inst_sram_en = 1'b0;
        tick();
        chk("t6_queue_empty", exp_ar_q.size() + exp_wr_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
